// File: rtl/add_seq_arb_pkg.sv
// add_seq_arb_pkg: shared types and constants for the sequential adder controller.
// Holds the controller state encoding and the requester ID values.

package add_seq_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/add_seq_arb_fadd_chunk.sv
// fadd / fadd_chunk: single-bit full adder cell and a CHUNK-bit ripple-carry
// adder slice built from it. Purely combinational.

module fadd (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module fadd_chunk #(
   parameter int CHUNK = 3
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] carry;

   assign carry[0] = cin;
   assign cout     = carry[CHUNK];

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      fadd u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

endmodule

// File: rtl/add_seq_arb.sv
// add_seq_arb: two-requester wide-operand adder that time-shares one CHUNK-bit
// ripple slice, summing least-significant chunk first with a held carry.
// Optional macro ADD_SEQ_ARB_RR_EN switches arbitration from fixed priority
// (req0 over req1) to a round-robin scheme with a 1-bit priority pointer.

module add_seq_arb #(
   parameter int WIDTH = 12,
   parameter int CHUNK = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id
);

   import add_seq_arb_pkg::*;

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = $clog2(NCHUNK) + 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q;
   logic [IDXW-1:0]  idx_q;
   logic             id_q;

   logic             grant_id;
   logic             idle;
   logic             accept;
   logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
   logic             slice_cout;

`ifdef ADD_SEQ_ARB_RR_EN
   logic             rr_ptr;

   // Round-robin pick: the pointed requester wins a tie, a lone requester always wins
   always_comb begin
      grant_id = REQ0;
      if (req0_valid && req1_valid) begin
         grant_id = rr_ptr;
      end else if (!req0_valid) begin
         grant_id = REQ1;
      end
   end

   // After every grant the pointer moves to the requester that was not served
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= REQ0;
      end else if (accept) begin
         rr_ptr <= ~grant_id;
      end
   end
`else
   // Fixed priority pick: req0 wins whenever it is valid
   always_comb begin
      grant_id = REQ0;
      if (!req0_valid) begin
         grant_id = REQ1;
      end
   end
`endif

   assign idle       = (state_q == IDLE);
   assign req0_ready = idle && req0_valid && (grant_id == REQ0);
   assign req1_ready = idle && req1_valid && (grant_id == REQ1);
   assign accept     = req0_ready || req1_ready;

   // Route the operand chunk addressed by the chunk index into the shared slice
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx_q == IDXW'(k)) begin
            slice_a = a_q[k*CHUNK +: CHUNK];
            slice_b = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   fadd_chunk #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Controller next state: accept in IDLE, walk the chunks in RUN, hold result in DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops any in-flight transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture on the handshake edge, then one chunk of sum and carry per RUN edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         id_q    <= REQ0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= (grant_id == REQ1) ? req1_a : req0_a;
                  b_q     <= (grant_id == REQ1) ? req1_b : req0_b;
                  carry_q <= (grant_id == REQ1) ? req1_cin : req0_cin;
                  idx_q   <= '0;
                  id_q    <= grant_id;
               end
            end
            RUN: begin
               for (int k = 0; k < NCHUNK; k++) begin
                  if (idx_q == IDXW'(k)) begin
                     sum_q[k*CHUNK +: CHUNK] <= slice_sum;
                  end
               end
               carry_q <= slice_cout;
               idx_q   <= idx_q + IDXW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = carry_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_add_seq_arb.sv
// tb_add_seq_arb: directed and random checks of add_seq_arb with a reference
// model of the handshake timing and a scoreboard of expected sums.
// Honours ADD_SEQ_ARB_RR_EN the same way the design does.

module tb_add_seq_arb;

   localparam int WIDTH  = 12;
   localparam int CHUNK  = 3;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk;
   logic             rst;
   logic             req0_valid, req0_ready, req0_cin;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_cin;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_cout, rsp_id;
   logic [WIDTH-1:0] rsp_sum;

   int nChecks = 0;
   int nErrors = 0;

   // Scoreboard entries are {id, cout, sum}
   logic [WIDTH+1:0] sbQ[$];
   int               mPhase;
   int               mCnt;
   logic             mPtr;
   int               nResp;
   logic [WIDTH-1:0] lastSum;
   logic             lastCout;
   logic             lastId;

   add_seq_arb #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic modelGrant(input logic v0, input logic v1);
`ifdef ADD_SEQ_ARB_RR_EN
      if (v0 && v1) return mPtr;
`endif
      return v0 ? 1'b0 : 1'b1;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model at the negedge,
   // advance the model by what the coming rising edge should do.
   task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                input logic c0, input logic v1, input logic [WIDTH-1:0] a1,
                                input logic [WIDTH-1:0] b1, input logic c1, input logic rr);
      logic             g;
      logic [WIDTH:0]   full;
      logic [WIDTH+1:0] e;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
      rsp_ready  = rr;
      @(negedge clk);
      g = modelGrant(v0, v1);
      checkOutput("req0_ready", req0_ready, (mPhase == 0) && v0 && (g == 1'b0));
      checkOutput("req1_ready", req1_ready, (mPhase == 0) && v1 && (g == 1'b1));
      checkOutput("rsp_valid", rsp_valid, mPhase == 2);
      if (mPhase == 2) begin
         if (sbQ.size() > 0) begin
            e = sbQ[0];
            checkOutput("rsp_sum", rsp_sum, e[WIDTH-1:0]);
            checkOutput("rsp_cout", rsp_cout, e[WIDTH]);
            checkOutput("rsp_id", rsp_id, e[WIDTH+1]);
         end
         if (rr) begin
            if (sbQ.size() > 0) void'(sbQ.pop_front());
            nResp++;
            lastSum  = rsp_sum;
            lastCout = rsp_cout;
            lastId   = rsp_id;
            mPhase   = 0;
         end
      end else if (mPhase == 1) begin
         mCnt++;
         if (mCnt == NCHUNK) mPhase = 2;
      end else if (v0 || v1) begin
         if (g) full = {1'b0, a1} + {1'b0, b1} + {{WIDTH{1'b0}}, c1};
         else   full = {1'b0, a0} + {1'b0, b0} + {{WIDTH{1'b0}}, c0};
         sbQ.push_back({g, full});
         mPhase = 1;
         mCnt   = 0;
         mPtr   = ~g;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleStep(input logic rr);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rr);
   endtask

   // Idle with rsp_ready high until one more response is taken, bounded
   task automatic waitResponse(input int bound, output int waited);
      int startResp;
      startResp = nResp;
      waited = 0;
      while (nResp == startResp && waited < bound) begin
         idleStep(1'b1);
         waited++;
      end
      if (nResp == startResp) checkOutput("response_timeout", nResp, startResp + 1);
   endtask

   task automatic applyReset();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("reset_rsp_valid_now", rsp_valid, 1'b0);
      sbQ.delete();
      mPhase = 0; mCnt = 0; mPtr = 1'b0;
      @(negedge clk);
      checkOutput("reset_rsp_sum", rsp_sum, '0);
      checkOutput("reset_rsp_cout", rsp_cout, 1'b0);
      checkOutput("reset_rsp_id", rsp_id, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waited;
      int k;
      int cyc;
      int target;
      logic expId;
      rst = 1'b1;
      nResp = 0;
      applyReset();

      // Ripple through every chunk
      applyStimulus(1'b1, 12'hFFF, 12'h001, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      waitResponse(20, waited);
      checkOutput("ripple_sum", lastSum, 12'h000);
      checkOutput("ripple_cout", lastCout, 1'b1);
      checkOutput("ripple_id", lastId, 1'b0);
      checkOutput("ripple_latency", waited, NCHUNK + 1);

      // Carry-in path from requester 1
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 12'h123, 12'h456, 1'b1, 1'b1);
      waitResponse(20, waited);
      checkOutput("cin_sum", lastSum, 12'h57A);
      checkOutput("cin_cout", lastCout, 1'b0);
      checkOutput("cin_id", lastId, 1'b1);

      // Contention: both valid every cycle
      k = 0;
      cyc = 0;
      while (k < 4 && cyc < 60) begin
         target = nResp;
         applyStimulus(1'b1, 12'h111, 12'h222, 1'b0, 1'b1, 12'h333, 12'h444, 1'b1, 1'b1);
         cyc++;
         if (nResp != target) begin
`ifdef ADD_SEQ_ARB_RR_EN
            expId = k[0];
`else
            expId = 1'b0;
`endif
            checkOutput("contention_id", lastId, expId);
            k++;
         end
      end
      checkOutput("contention_count", k, 4);

      // Backpressure: hold the result for 10 cycles while both requesters push
      idleStep(1'b1);
      applyStimulus(1'b1, 12'h0AB, 12'h101, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < NCHUNK; i++) idleStep(1'b0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 12'h777, 12'h001, 1'b0, 1'b1, 12'h555, 12'h005, 1'b0, 1'b0);
      target = nResp;
      applyStimulus(1'b1, 12'h777, 12'h001, 1'b0, 1'b1, 12'h555, 12'h005, 1'b0, 1'b1);
      checkOutput("bp_released", nResp, target + 1);
      checkOutput("bp_sum", lastSum, 12'h1AD);
      applyStimulus(1'b1, 12'h777, 12'h001, 1'b0, 1'b1, 12'h555, 12'h005, 1'b0, 1'b1);
      checkOutput("bp_next_accept", mPhase, 1);
      waitResponse(20, waited);

      // Reset in the middle of RUN at chunk index 2
      applyStimulus(1'b1, 12'hABC, 12'h321, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      idleStep(1'b1);
      idleStep(1'b1);
      target = nResp;
      applyReset();
      for (int i = 0; i < NCHUNK + 3; i++) idleStep(1'b1);
      checkOutput("reset_no_response", nResp, target);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 12'h800, 12'h800, 1'b1, 1'b1);
      waitResponse(20, waited);
      checkOutput("post_reset_sum", lastSum, 12'h001);
      checkOutput("post_reset_cout", lastCout, 1'b1);
      checkOutput("post_reset_id", lastId, 1'b1);

      // Random traffic
      target = nResp + 1000;
      cyc = 0;
      while (nResp < target && cyc < 30000) begin
         applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0));
         cyc++;
      end
      checkOutput("random_resp_count", nResp, target);
      if (mPhase != 0) waitResponse(20, waited);
      checkOutput("scoreboard_drained", sbQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
